operand_pingpong_buf: RTL and testbench
=======================================

# operand_pingpong_buf

Double-buffered operand store that answers the read requests of the NxN systolic matrix engine. A host writes A-column and B-row vectors into one bank while the engine reads the other bank through its `addr`/`rd_en_n` port. Bank ownership is exchanged by a commit/done handshake. The block also reports the committed depth as the engine's `k_param`, and sits between the SoC host write path and the systolic engine's operand inputs.

## Interface
- `N`, 8 — operand vector width in bytes; matches the engine's `N`.
- `DEPTH`, 256 — vectors per operand per bank; legal range 1..256.
- `AW`, 13 — address width; matches the engine's `addr`.
- `clk` in 1 — single clock.
- `rst_n` in 1 — one clock; reset is asynchronous and active-low.
- `wr_en` in 1 — host write strobe.
- `wr_sel` in 1 — 0 = A store, 1 = B store.
- `wr_addr` in AW — host vector index.
- `wr_data` in N×8 — host vector, packed `[N-1:0][7:0]`.
- `commit` in 1 — pulse: host bank complete; hand it to the reader.
- `host_ready` out 1 — host bank is writable.
- `addr` in AW — engine read index.
- `rd_en_n` in 1 — engine read enable, active low.
- `rd_done` in 1 — engine `done` pulse; releases the read bank.
- `data_a` out N×8 — A vector, registered.
- `data_b` out N×8 — B vector, registered.
- `rd_valid` out 1 — read bank holds committed data; engine may `start`.
- `k_out` out 8 — committed depth of the read bank; drives the engine's `k_param`.
- `wr_err` out 1 — sticky error flag; cleared only by reset.

## Operation
- Two banks, each holding an A store and a B store of DEPTH×N bytes, plus `full[b]` and `fill[b]` (9 bits).
- Pointers: `wb` is the write-bank pointer and `rb` is the read-bank pointer. Both reset to 0.
- `host_ready = !full[wb]`.
- `rd_valid = full[rb]`.
- `k_out` = `fill[rb]` when `full[rb]`, else 0. A fill of 256 saturates `k_out` to 255.
- Accepted write: requires `wr_en && host_ready && wr_addr < DEPTH`.
  - Stores `wr_data` into bank `wb`, store `wr_sel`, entry `wr_addr`.
  - Sets `fill[wb] = max(fill[wb], wr_addr+1)`.
- Rejected write: `wr_en` with `!host_ready` or `wr_addr >= DEPTH`.
  - Memory is not written.
  - `wr_err` is set to 1.
- Commit: `commit && host_ready` sets `full[wb]=1` and toggles `wb`. A commit with `!host_ready` is ignored and sets `wr_err`.
- Release: `rd_done && full[rb]` clears `full[rb]`, clears `fill[rb]`, and toggles `rb`. A `rd_done` with `!full[rb]` is ignored.
- Simultaneous commit and release in one cycle: both take effect, each on its own pointer.
- A write in the same cycle as commit lands in the bank being committed and is included in its fill.
- Read: when `rd_en_n==0 && rd_valid && addr < DEPTH`, the next cycle's `data_a`/`data_b` equal A/B entry `addr` of bank `rb`.
  - In every other case, the next-cycle data is all zeros.
- Entries are never zeroed on release. Stale data beyond `fill` is readable.

## Timing
- Read latency is exactly 1 cycle: sample at edge t, data valid after edge t. This matches the engine's one-cycle `shift_cnt` lag.
- A commit at edge t makes `rd_valid` rise after edge t when `rb` pointed at that bank.
- A release at edge t frees the bank; `host_ready` rises after edge t when `wb==rb`-old.
- Reset values: `host_ready=1`, `rd_valid=0`, `k_out=0`, `data_a=data_b=0`, `wr_err=0`, all `full`/`fill` = 0.
- Memory contents are not reset.
- Reset asserted mid-transfer: all flags and pointers return to reset values immediately (async); outputs reach reset values in the same cycle.

## Structure
- Shared package `soc_pkg`:
  - `operand_vec_t` (`logic [N-1:0][7:0]`, with `N` as a package constant of 8).
  - Constants `OPB_DEPTH_MAX=256` and `ENG_AW=13`.
- One sub-module, `pp_bank_ram`: 1-write/1-read RAM with a registered read and a read-zero control.
  - Instantiated four times: bank × operand.
- Top level holds the pointers, `full`/`fill` registers, error logic, and the read-bank mux.

## Test plan
- Reset, then idle: `host_ready=1`, `rd_valid=0`, `k_out=0`, `data_a=0`.
- Write A[0..3] = `{8{8'hi}}` and B[0..3] = `{8{8'h10+i}}` for i = 0..3, then commit → `rd_valid=1`, `k_out=4`. Reading with `addr=2` one cycle later → `data_a` all bytes 2, `data_b` all bytes 0x12.
- Fill and commit both banks → `host_ready=0`. A further `wr_en` does not alter memory and `wr_err=1`. Then `rd_done` → `host_ready=1`, and `k_out` reports the second bank's fill.
- `commit` and `rd_done` in the same cycle with one bank full → `wb` and `rb` both toggle; `rd_valid` remains 1 with the new bank's `k_out`.
- Read with `addr=DEPTH`, or with `rd_en_n=1`, or with `rd_valid=0` → `data_a=data_b=0` the next cycle.
- Assert `rst_n` low mid-read burst → outputs zero immediately. After release, prior data is not visible (`rd_valid=0`).

Source files
------------

// File: rtl/soc_pkg.sv
// Shared SoC types and constants for the systolic engine operand path.
`default_nettype none

package soc_pkg;

  localparam int N             = 8;
  localparam int OPB_DEPTH_MAX = 256;
  localparam int ENG_AW        = 13;
  localparam int OPB_IW        = 8;

  typedef logic [N-1:0][7:0] operand_vec_t;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } opnd_sel_e;

  // Engine k_param is 8 bits; a full 256-deep bank reports 255.
  function automatic logic [7:0] k_sat(input logic [8:0] fill);
    return fill[8] ? 8'hFF : fill[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pp_bank_ram.sv
// One operand store of one bank: 1 write port, 1 registered read port with read-zero.
`default_nettype none

module pp_bank_ram #(
  parameter int DEPTH = 256,
  parameter int W     = 64,
  parameter int IW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          rd_zero,
  input  logic [IW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register resets so the engine sees zeros during reset; the array does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rd_zero) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/operand_pingpong_buf.sv
// Double-buffered A/B operand store: host fills one bank while the systolic engine reads the other.
`default_nettype none

module operand_pingpong_buf #(
  parameter int N     = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                wr_sel,
  input  logic [AW-1:0]       wr_addr,
  input  logic [N-1:0][7:0]   wr_data,
  input  logic                commit,
  output logic                host_ready,
  input  logic [AW-1:0]       addr,
  input  logic                rd_en_n,
  input  logic                rd_done,
  output logic [N-1:0][7:0]   data_a,
  output logic [N-1:0][7:0]   data_b,
  output logic                rd_valid,
  output logic [7:0]          k_out,
  output logic                wr_err
);

  import soc_pkg::*;

  localparam int IW = OPB_IW;

  logic            wb_q, wb_d;
  logic            rb_q, rb_d;
  logic [1:0]      full_q, full_d;
  logic [1:0][8:0] fill_q, fill_d;
  logic            wr_err_q, wr_err_d;

  logic            wr_ok, rd_ok, commit_ok, release_ok;
  logic [8:0]      wr_idx1;

  logic [1:0][N*8-1:0] ram_a;
  logic [1:0][N*8-1:0] ram_b;

  always_comb begin
    host_ready = !full_q[wb_q];
    rd_valid   = full_q[rb_q];
    wr_ok      = wr_en && host_ready && (wr_addr < AW'(DEPTH));
    rd_ok      = !rd_en_n && rd_valid && (addr < AW'(DEPTH));
    commit_ok  = commit && host_ready;
    release_ok = rd_done && rd_valid;
    wr_idx1    = {1'b0, wr_addr[IW-1:0]} + 9'd1;

    wb_d     = wb_q;
    rb_d     = rb_q;
    full_d   = full_q;
    fill_d   = fill_q;
    wr_err_d = wr_err_q;

    // A write in the commit cycle targets the same bank, so fill is updated before commit.
    if (wr_ok && (wr_idx1 > fill_q[wb_q])) begin
      fill_d[wb_q] = wr_idx1;
    end
    if (commit_ok) begin
      full_d[wb_q] = 1'b1;
      wb_d         = !wb_q;
    end
    // Commit needs !full[wb] and release needs full[rb], so both never hit one bank.
    if (release_ok) begin
      full_d[rb_q] = 1'b0;
      fill_d[rb_q] = 9'd0;
      rb_d         = !rb_q;
    end
    if ((wr_en && !wr_ok) || (commit && !host_ready)) begin
      wr_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      full_q   <= '0;
      fill_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      full_q   <= full_d;
      fill_q   <= fill_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Non-selected banks drive zero, so the read mux reduces to an OR.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    pp_bank_ram #(.DEPTH(DEPTH), .W(N*8), .IW(IW)) u_ram_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (wr_ok && (wb_q == 1'(b)) && (wr_sel == SEL_A)),
      .waddr   (wr_addr[IW-1:0]),
      .wdata   (wr_data),
      .rd_zero (!(rd_ok && (rb_q == 1'(b)))),
      .raddr   (addr[IW-1:0]),
      .rdata   (ram_a[b])
    );
    pp_bank_ram #(.DEPTH(DEPTH), .W(N*8), .IW(IW)) u_ram_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (wr_ok && (wb_q == 1'(b)) && (wr_sel == SEL_B)),
      .waddr   (wr_addr[IW-1:0]),
      .wdata   (wr_data),
      .rd_zero (!(rd_ok && (rb_q == 1'(b)))),
      .raddr   (addr[IW-1:0]),
      .rdata   (ram_b[b])
    );
  end

  assign data_a = ram_a[0] | ram_a[1];
  assign data_b = ram_b[0] | ram_b[1];
  assign k_out  = rd_valid ? k_sat(fill_q[rb_q]) : 8'd0;
  assign wr_err = wr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_pingpong_buf.sv
// Directed self-checking bench for operand_pingpong_buf.
`default_nettype none
`timescale 1ns/1ps

module tb_operand_pingpong_buf;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en, wr_sel, commit, rd_en_n, rd_done;
  logic [12:0]       wr_addr, addr;
  logic [7:0][7:0]   wr_data;
  logic              host_ready, rd_valid, wr_err;
  logic [7:0][7:0]   data_a, data_b;
  logic [7:0]        k_out;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  operand_pingpong_buf #(.N(8), .DEPTH(256), .AW(13)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .host_ready (host_ready),
    .addr       (addr),
    .rd_en_n    (rd_en_n),
    .rd_done    (rd_done),
    .data_a     (data_a),
    .data_b     (data_b),
    .rd_valid   (rd_valid),
    .k_out      (k_out),
    .wr_err     (wr_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; commit = 1'b0; rd_done = 1'b0; rd_en_n = 1'b1;
  endtask

  task automatic wr(input logic sel, input int a, input logic [63:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = a[12:0]; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input int a);
    rd_en_n = 1'b0; addr = a[12:0];
    tick();
    rd_en_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; addr = '0;
    idle();
    #1;
    chk("rst_async_data_a", data_a, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_host_ready", {63'd0, host_ready}, 64'd1);
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_k_out", {56'd0, k_out}, 64'd0);
    chk("rst_wr_err", {63'd0, wr_err}, 64'd0);
    chk("rst_data_b", data_b, 64'd0);

    // Bank 0: A[i]={8{i}}, B[i]={8{0x10+i}}
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, i, rep(8'(i)));
      wr(1'b1, i, rep(8'(8'h10 + i)));
    end
    commit = 1'b1; tick(); commit = 1'b0;
    chk("c0_rd_valid", {63'd0, rd_valid}, 64'd1);
    chk("c0_k_out", {56'd0, k_out}, 64'd4);
    chk("c0_host_ready", {63'd0, host_ready}, 64'd1);
    rd(2);
    chk("rd2_data_a", data_a, rep(8'h02));
    chk("rd2_data_b", data_b, rep(8'h12));
    rd(256);
    chk("rd_depth_a", data_a, 64'd0);
    chk("rd_depth_b", data_b, 64'd0);
    addr = 13'd1; tick();
    chk("rd_disabled_a", data_a, 64'd0);

    // Bank 1: fill reaches 10 through B[9]
    for (int i = 0; i < 6; i++) wr(1'b0, i, rep(8'(8'h20 + i)));
    wr(1'b1, 9, rep(8'hB9));
    commit = 1'b1; tick(); commit = 1'b0;
    chk("both_full_host_ready", {63'd0, host_ready}, 64'd0);
    chk("both_full_k_out", {56'd0, k_out}, 64'd4);
    wr(1'b0, 0, rep(8'hFF));
    chk("rej_full_wr_err", {63'd0, wr_err}, 64'd1);
    rd(0);
    chk("rej_mem_untouched", data_a, 64'd0);
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("rel_host_ready", {63'd0, host_ready}, 64'd1);
    chk("rel_rd_valid", {63'd0, rd_valid}, 64'd1);
    chk("rel_k_out", {56'd0, k_out}, 64'd10);
    rd(2);
    chk("b1_rd2_a", data_a, rep(8'h22));
    rd(9);
    chk("b1_rd9_b", data_b, rep(8'hB9));

    // Bank 0 refill; write+commit+release in one cycle
    for (int i = 0; i < 3; i++) wr(1'b0, i, rep(8'(8'h30 + i)));
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 13'd7; wr_data = rep(8'h37);
    commit = 1'b1; rd_done = 1'b1;
    tick();
    idle();
    chk("swap_rd_valid", {63'd0, rd_valid}, 64'd1);
    chk("swap_k_out", {56'd0, k_out}, 64'd8);
    chk("swap_host_ready", {63'd0, host_ready}, 64'd1);
    rd(1);
    chk("swap_rd1_a", data_a, rep(8'h31));
    chk("stale_rd1_b", data_b, rep(8'h11));
    rd(7);
    chk("swap_rd7_a", data_a, rep(8'h37));
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("empty_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("empty_k_out", {56'd0, k_out}, 64'd0);
    rd(1);
    chk("rd_invalid_a", data_a, 64'd0);

    // Saturation: bank 1 with entry 255 written
    wr(1'b0, 255, rep(8'hA5));
    commit = 1'b1; tick(); commit = 1'b0;
    chk("sat_k_out", {56'd0, k_out}, 64'd255);
    rd(255);
    chk("rd255_a", data_a, rep(8'hA5));

    // Async reset in the middle of a read burst
    rd_en_n = 1'b0; addr = 13'd255;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data_a", data_a, 64'd0);
    chk("mid_rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("mid_rst_k_out", {56'd0, k_out}, 64'd0);
    chk("mid_rst_wr_err", {63'd0, wr_err}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_data_a", data_a, 64'd0);
    chk("post_rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    idle();

    wr(1'b0, 300, rep(8'h55));
    chk("rej_addr_wr_err", {63'd0, wr_err}, 64'd1);
    chk("rej_addr_host_ready", {63'd0, host_ready}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
